case_2_mul_pipe_acc: RTL and testbench

- Parametrised pipelined successor to the combinational din0*din1 multiplier cores in the case_2 datapath.
- Adds NUM_STAGE register stages with a valid/ready handshake and global stall.
- Supports selectable signed/unsigned operands and per-beat optional multiply-accumulate.
- Sits between HLS-scheduled operand producers and result consumers wherever a multi-cycle multiplier or MAC is bound.

---
 rtl/case_2_mul_pipe_acc.sv | 82 ++++++++
 tb/tb_case_2_mul_pipe_acc.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/case_2_mul_pipe_acc.sv
// case_2_mul_pipe_acc: NUM_STAGE-deep multiplier/MAC with valid/ready stall.
// Define CASE_2_MUL_PIPE_SAT_EN to saturate results instead of wrapping.
module case_2_mul_pipe_acc #(
    parameter int ID = 1,
    parameter int NUM_STAGE = 3,
    parameter int din0_WIDTH = 6,
    parameter int din1_WIDTH = 4,
    parameter int dout_WIDTH = 8,
    parameter int SIGNED = 1
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [din0_WIDTH-1:0] din0,
    input  logic [din1_WIDTH-1:0] din1,
    input  logic                  acc_en,
    input  logic                  acc_first,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [dout_WIDTH-1:0] dout,
    output logic                  ovf
);
    localparam int PW = din0_WIDTH + din1_WIDTH;
    localparam int FW = (dout_WIDTH > PW ? dout_WIDTH : PW) + 1;
    localparam int D = NUM_STAGE > 1 ? NUM_STAGE - 1 : 1;
    localparam bit SX = SIGNED != 0;
    typedef struct packed {
        logic                  v;
        logic                  en;
        logic                  first;
        logic [din0_WIDTH-1:0] a;
        logic [din1_WIDTH-1:0] b;
    } beat_t;
    beat_t in_b, f;
    beat_t s [D];
    logic ce, over, under;
    logic [dout_WIDTH-1:0] acc, red;
    logic [FW-1:0] ax, bx, px, accx, r;
    assign ce = !out_valid || out_ready;
    assign in_ready = ce;
    assign in_b = '{v: in_valid, en: acc_en, first: acc_first, a: din0, b: din1};
    // With a single stage the operands feed the result register directly.
    assign f = NUM_STAGE == 1 ? in_b : s[D-1];
    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            for (int i = 0; i < D; i++) s[i] <= '0;
        end else if (ce) begin
            s[0] <= in_b;
            for (int i = 1; i < D; i++) s[i] <= s[i-1];
        end
    // Operands extended to FW so the FW-bit product equals the true extended product.
    always_comb begin
        ax = {{(FW-din0_WIDTH){SX && f.a[din0_WIDTH-1]}}, f.a};
        bx = {{(FW-din1_WIDTH){SX && f.b[din1_WIDTH-1]}}, f.b};
        px = ax * bx;
        accx = {{(FW-dout_WIDTH){SX && acc[dout_WIDTH-1]}}, acc};
        r = f.en && !f.first ? accx + px : px;
        over = SX ? !r[FW-1] && |r[FW-2:dout_WIDTH-1] : |r[FW-1:dout_WIDTH];
        under = SX && r[FW-1] && !(&r[FW-2:dout_WIDTH-1]);
`ifdef CASE_2_MUL_PIPE_SAT_EN
        red = over ? {!SX, {(dout_WIDTH-1){1'b1}}} :
              under ? {1'b1, {(dout_WIDTH-1){1'b0}}} : r[dout_WIDTH-1:0];
`else
        red = r[dout_WIDTH-1:0];
`endif
    end
    always_ff @(posedge ap_clk or negedge ap_rst_n)
        if (!ap_rst_n) begin
            out_valid <= 1'b0;
            dout <= '0;
            ovf <= 1'b0;
            acc <= '0;
        end else if (ce) begin
            out_valid <= f.v;
            if (f.v) begin
                dout <= red;
                ovf <= over || under;
                if (f.en) acc <= red;
            end
        end
endmodule

// File: tb/tb_case_2_mul_pipe_acc.sv
// tb_case_2_mul_pipe_acc: signed and unsigned instances against an integer reference model.
module tb_case_2_mul_pipe_acc;
    localparam int N = 3;
`ifdef CASE_2_MUL_PIPE_SAT_EN
    localparam bit SAT = 1;
`else
    localparam bit SAT = 0;
`endif
    logic clk = 0, rst_n = 0, in_valid = 0, acc_en = 0, acc_first = 0, out_ready = 1;
    logic [5:0] din0 = 0;
    logic [3:0] din1 = 0;
    logic rdy_s, rdy_u, ov_s, ov_u, of_s, of_u;
    logic [7:0] d_s, d_u;
    int checks = 0, failures = 0;
    typedef struct {logic [7:0] d; logic o; int c;} exp_t;
    exp_t qs[$], qu[$];
    logic [17:0] got[$];
    int acc_s, acc_u, cec = 0;
    bit stall_prev = 0;
    logic [7:0] prev_d;
    int sa[6] = '{1, 9, 17, 33, 45, 62};
    int sb[6] = '{2, 15, 7, 9, 4, 11};

    always #5 clk = ~clk;

    case_2_mul_pipe_acc #(.NUM_STAGE(N), .SIGNED(1)) dut_s (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_s),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_first(acc_first),
        .out_valid(ov_s), .out_ready(out_ready), .dout(d_s), .ovf(of_s));
    case_2_mul_pipe_acc #(.NUM_STAGE(N), .SIGNED(0)) dut_u (
        .ap_clk(clk), .ap_rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy_u),
        .din0(din0), .din1(din1), .acc_en(acc_en), .acc_first(acc_first),
        .out_valid(ov_u), .out_ready(out_ready), .dout(d_u), .ovf(of_u));

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    function automatic int sx(int v, int w, bit sg);
        return (sg && v[w-1]) ? v - (1 << w) : v;
    endfunction

    function automatic logic [8:0] model(bit sg, logic [5:0] a, logic [3:0] b, bit en, bit first,
                                         input int acc, output int nacc);
        int p, r, lo, hi, red;
        p = sx(int'(a), 6, sg) * sx(int'(b), 4, sg);
        r = (en && !first) ? acc + p : p;
        lo = sg ? -128 : 0;
        hi = sg ? 127 : 255;
        red = SAT ? (r < lo ? lo : r > hi ? hi : r) : sx(r & 255, 8, sg);
        nacc = en ? red : acc;
        return {r < lo || r > hi, red[7:0]};
    endfunction

    always @(negedge clk) begin
        exp_t e;
        logic [8:0] m;
        int na;
        if (!rst_n) begin
            chk("rst_valid", {30'd0, ov_u, ov_s}, 0);
            qs.delete();
            qu.delete();
            acc_s = 0;
            acc_u = 0;
            stall_prev = 0;
        end else begin
            chk("in_ready_s", rdy_s, !ov_s || out_ready);
            chk("in_ready_u", rdy_u, !ov_u || out_ready);
            if (stall_prev) chk("hold_dout", {ov_s, d_s}, {1'b1, prev_d});
            if (in_valid && rdy_s) begin
                m = model(1, din0, din1, acc_en, acc_first, acc_s, na);
                acc_s = na;
                qs.push_back('{m[7:0], m[8], cec});
                m = model(0, din0, din1, acc_en, acc_first, acc_u, na);
                acc_u = na;
                qu.push_back('{m[7:0], m[8], cec});
            end
            if (ov_s && out_ready) begin
                if (qs.size() == 0) chk("s_unexpected", 1, 0);
                else begin
                    e = qs.pop_front();
                    chk("s_dout", d_s, e.d);
                    chk("s_ovf", of_s, e.o);
                    chk("s_latency", cec - e.c, N);
                end
            end
            if (ov_u && out_ready) begin
                if (qu.size() == 0) chk("u_unexpected", 1, 0);
                else begin
                    e = qu.pop_front();
                    chk("u_dout", d_u, e.d);
                    chk("u_ovf", of_u, e.o);
                    chk("u_latency", cec - e.c, N);
                end
            end
            if (ov_s && ov_u && out_ready) got.push_back({of_u, d_u, of_s, d_s});
            stall_prev = ov_s && !out_ready;
            prev_d = d_s;
            if (rdy_s) cec++;
        end
    end

    task automatic push(logic [5:0] a, logic [3:0] b, bit en, bit first);
        int t = 0;
        in_valid = 1;
        din0 = a;
        din1 = b;
        acc_en = en;
        acc_first = first;
        @(negedge clk);
        while (!rdy_s && t < 20) begin
            t++;
            @(negedge clk);
        end
        if (!rdy_s) chk("push_timeout", 0, 1);
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && (qs.size() != 0 || qu.size() != 0); i++) @(negedge clk);
        if (qs.size() != 0 || qu.size() != 0) chk("drain_timeout", 1, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic expgot(string n, int i, logic [8:0] s, logic [8:0] u);
        if (i >= got.size()) chk({n, "_missing"}, 0, 1);
        else chk(n, got[i], {u, s});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("rst_dout_ovf", {of_u, d_u, of_s, d_s}, 0);
        @(posedge clk);
        #1 rst_n = 1;
        #1 chk("ready_after_rst", {rdy_u, rdy_s}, 2'b11);
        got.delete();
        push(6'd5, 4'hD, 0, 0);
        push(6'd31, 4'd7, 0, 0);
        drain();
        expgot("neg_product", 0, 9'h0F1, 9'h041);
        expgot("pos_overflow", 1, SAT ? 9'h17F : 9'h1D9, 9'h0D9);
        got.delete();
        push(6'h20, 4'h8, 0, 0);
        drain();
        expgot("min_times_min", 0, SAT ? 9'h17F : 9'h100, SAT ? 9'h1FF : 9'h100);
        got.delete();
        push(6'd2, 4'd3, 1, 1);
        push(6'd4, 4'd5, 1, 0);
        push(6'h3F, 4'd2, 1, 0);
        drain();
        expgot("chain_0", 0, 9'h006, 9'h006);
        expgot("chain_1", 1, 9'h01A, 9'h01A);
        expgot("chain_2", 2, 9'h018, 9'h098);
        got.delete();
        push(6'h3F, 4'hF, 0, 0);
        drain();
        expgot("max_unsigned", 0, 9'h001, SAT ? 9'h1FF : 9'h1B1);
        got.delete();
        begin
            int k = 0;
            for (int cyc = 1; cyc <= 14; cyc++) begin
                out_ready = !(cyc >= 4 && cyc <= 6);
                in_valid = k < 6;
                din0 = 6'(sa[k%6]);
                din1 = 4'(sb[k%6]);
                acc_en = 0;
                @(negedge clk);
                chk($sformatf("stream_ready_c%0d", cyc), rdy_s, !(cyc >= 4 && cyc <= 6));
                if (in_valid && rdy_s) k++;
                @(posedge clk);
                #1;
            end
            in_valid = 0;
            out_ready = 1;
            chk("stream_count", got.size(), 6);
        end
        drain();
        push(6'd3, 4'd3, 1, 1);
        push(6'd2, 4'd2, 1, 0);
        rst_n = 0;
        #1 chk("mid_rst_valid", {ov_u, ov_s}, 0);
        chk("mid_rst_ready", rdy_s, 1);
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        got.delete();
        push(6'd1, 4'd7, 1, 1);
        push(6'd2, 4'd2, 1, 0);
        drain();
        repeat (4) @(posedge clk);
        #1;
        chk("post_rst_count", got.size(), 2);
        expgot("post_rst_0", 0, 9'h007, 9'h007);
        expgot("post_rst_1", 1, 9'h00B, 9'h00B);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
